itrx_ahbl_sram_slv: RTL and testbench
=====================================

// Module: itrx_ahbl_sram_slv
// PURPOSE
//  AHB-Lite subordinate (responder) fronting a flop-based memory; completes the
//  manager side of the AMBA3 AHB-Lite interface types. Sits behind the AHB-Lite
//  decoder/mux, one hsel per instance. Supports programmable wait states,
//  byte/halfword/word lanes and the two-cycle ERROR response.
// PARAMETERS
//  AW          12  byte-address width; memory depth = 2**AW / (DW/8) words
//  DW          32  data width; 32 or 64 only
//  WAIT_STATES  0  extra data-phase cycles per OKAY transfer, 0..7
// PORTS
//  hclk       in   1      clock
//  hreset     in   1      reset; synchronous, active-high
//  hsel       in   1      slave select from decoder
//  haddr      in   AW     byte address (address phase)
//  htrans     in   2      te_htrans
//  hwrite     in   1      te_hwrite
//  hsize      in   3      te_hsize
//  hburst     in   3      te_hburst; ignored (every beat decoded on its own)
//  hprot      in   4      ts_hprot; ignored
//  hwdata     in   DW     write data (data phase)
//  hready     in   1      bus-wide ready (mux output)
//  hreadyout  out  1      this slave's ready
//  hresp      out  1      te_hresp
//  hrdata     out  DW     read data
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=OKAY, hrdata=0, FSM=S_IDLE, pending phase dropped.
//   Memory contents are not reset.
//  Accept: hsel & hready & htrans[1] (NONSEQ/SEQ) at a rising edge latches
//   haddr/hwrite/hsize into addr_q/wr_q/size_q. IDLE/BUSY or !hsel: no
//   transfer; next cycle is zero-wait OKAY.
//  Error check at accept: hsize > log2(DW/8), or haddr not aligned to hsize.
//  FSM:
//   S_IDLE: accept+err -> S_ERR1; accept+ok -> S_WAIT if WAIT_STATES>0, else
//     S_DATA.
//   S_WAIT: hreadyout=0, hresp=OKAY, down-counter from WAIT_STATES;
//     at count 1 -> S_DATA.
//   S_DATA: hreadyout=1, hresp=OKAY. Transfer completes at this edge. A new
//     accept in the same cycle re-enters S_WAIT/S_DATA/S_ERR1; else -> S_IDLE.
//   S_ERR1: hreadyout=0, hresp=ERROR -> S_ERR2.
//   S_ERR2: hreadyout=1, hresp=ERROR. Accept allowed (manager may cancel with
//     IDLE) -> S_IDLE/S_WAIT/S_DATA/S_ERR1 as above.
//  OKAY latency: WAIT_STATES+1 cycles per data phase. Back-to-back pipelined
//   NONSEQ/SEQ sustain 1 beat/clk when WAIT_STATES=0.
//  Write: in S_DATA, lanes set by size_q and addr_q low bits get hwdata at the
//   edge; other lanes unchanged. Errored writes never modify memory.
//  Read: in S_DATA of a read, hrdata = mem[addr_q word], full word on all lanes.
//   hrdata = 0 in every other state.
//  RAW: a write data phase followed directly by a read of the same address
//   returns the new data (write commits before the read data phase).
//  hreset asserted mid-wait or mid-error: next cycle hreadyout=1, hresp=OKAY;
//   an in-flight write is discarded.
// TESTING
//  1 Reset: hreset=1 two clks -> hreadyout=1, hresp=0, hrdata=0.
//  2 WAIT_STATES=0, DW=32: NONSEQ WORD write 0xDEADBEEF @0x010, then read @0x010
//    -> hreadyout high throughout; read data phase hrdata=0xDEADBEEF.
//  3 Byte lanes: write BYTE 0x5A @0x013 over 0x11223344 -> word read =0x5A223344;
//    HALFWORD 0xA5A5 @0x010 -> 0x5A22A5A5.
//  4 WAIT_STATES=3: single read -> hreadyout low 3 clks, high on 4th with data.
//  5 Error: WORD @0x012 (misaligned), then DBLWORD @0x000 -> each gives
//    hreadyout=0/hresp=1 then 1/1; memory unchanged; next IDLE -> OKAY.
//  6 hreset asserted in 2nd wait cycle of a write -> next clk hreadyout=1,
//    hresp=0; later read of that address returns its pre-write value.

Source files
------------

// File: rtl/itrx_ahbl_sram_slv.sv
// AHB-Lite subordinate over a flop memory: WAIT_STATES+1 cycle OKAY data phase, two-cycle ERROR.
// Backpressure: hreadyout drops during wait states and the first ERROR cycle.
module itrx_ahbl_sram_slv #(
    parameter int AW          = 12,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);
    localparam int NB    = DW / 8;
    localparam int OB    = $clog2(NB);
    localparam int DEPTH = 2 ** (AW - OB);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [2:0]    size_q, size_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] mem [0:DEPTH-1];

    logic          accept, size_err, misalign;
    logic [NB-1:0] be;
    logic [OB-1:0] off;
    logic [AW-OB-1:0] widx;
    logic          we;
    logic          unused_ok;

    assign unused_ok = ^{hburst, hprot, htrans[0]};
    assign accept    = hsel & hready & htrans[1];
    assign off       = addr_q[OB-1:0];
    assign widx      = addr_q[AW-1:OB];

    always_comb begin
        size_err = (hsize > 3'(OB));
        case (hsize)
            3'd1:    misalign = haddr[0];
            3'd2:    misalign = |haddr[1:0];
            3'd3:    misalign = |haddr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd1) state_d = S_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all drive hreadyout=1, so a new address phase can land here
                state_d = S_IDLE;
                if (accept) begin
                    addr_d = haddr;
                    wr_d   = hwrite;
                    size_d = hsize;
                    if (size_err || misalign) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
        end
    end

    // A lane is written when it falls inside the naturally aligned 2**size_q byte block
    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            if (((OB'(b) ^ off) >> size_q) == '0) be[b] = 1'b1;
        end
    end

    assign we = (state_q == S_DATA) && wr_q && !hreset;

    always_ff @(posedge hclk) begin
        for (int b = 0; b < NB; b++) begin
            if (we && be[b]) mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    assign hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
    assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
    assign hrdata    = (state_q == S_DATA && !wr_q) ? mem[widx] : '0;
endmodule

// File: tb/tb_itrx_ahbl_sram_slv.sv
// Directed bench: one zero-wait instance and one 3-wait instance share a bus; sel_dut picks the target.
module tb_itrx_ahbl_sram_slv;
    logic        hclk = 1'b0;
    logic        hreset;
    logic        bus_sel;
    logic        sel_dut;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hsel0, hsel3;
    logic        ro0, ro3, rsp0, rsp3;
    logic [31:0] rd0, rd3;
    logic        rdy_m, rsp_m;
    logic [31:0] rd_m;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    assign hsel0  = bus_sel & !sel_dut;
    assign hsel3  = bus_sel & sel_dut;
    assign hready = sel_dut ? ro3 : ro0;
    assign rdy_m  = sel_dut ? ro3 : ro0;
    assign rsp_m  = sel_dut ? rsp3 : rsp0;
    assign rd_m   = sel_dut ? rd3 : rd0;

    itrx_ahbl_sram_slv #(.AW(12), .DW(32), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0));

    itrx_ahbl_sram_slv #(.AW(12), .DW(32), .WAIT_STATES(3)) u3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(ro3), .hresp(rsp3), .hrdata(rd3));

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_ap(input logic [11:0] a, input logic wr, input logic [2:0] sz);
        bus_sel = 1'b1;
        haddr   = a;
        hwrite  = wr;
        hsize   = sz;
        htrans  = 2'b10;
    endtask

    task automatic set_idle();
        bus_sel = 1'b0;
        htrans  = 2'b00;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d);
        int n = 0;
        set_ap(a, 1'b1, sz);
        step();
        hwdata = d;
        set_idle();
        while (!rdy_m && n < 16) begin
            step();
            n++;
        end
        checks++;
        if (!rdy_m) begin
            errors++;
            $display("FAIL write_timeout: hreadyout=%0b required 1", rdy_m);
        end
        step();
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        set_ap(a, 1'b0, 3'd2);
        step();
        set_idle();
        while (!rdy_m && n < 16) begin
            step();
            n++;
        end
        checks++;
        if (!rdy_m) begin
            errors++;
            $display("FAIL read_timeout: hreadyout=%0b required 1", rdy_m);
        end
        d = rd_m;
        step();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        step();
        step();
        hreset = 1'b0;
        checks += 6;
        if (ro0 !== 1'b1)   begin errors++; $display("FAIL reset_rdy0: got %0b want 1", ro0); end
        if (rsp0 !== 1'b0)  begin errors++; $display("FAIL reset_resp0: got %0b want 0", rsp0); end
        if (rd0 !== 32'h0)  begin errors++; $display("FAIL reset_rdata0: got %08h want 0", rd0); end
        if (ro3 !== 1'b1)   begin errors++; $display("FAIL reset_rdy3: got %0b want 1", ro3); end
        if (rsp3 !== 1'b0)  begin errors++; $display("FAIL reset_resp3: got %0b want 0", rsp3); end
        if (rd3 !== 32'h0)  begin errors++; $display("FAIL reset_rdata3: got %08h want 0", rd3); end
    endtask

    task automatic test_back_to_back();
        sel_dut = 1'b0;
        set_ap(12'h010, 1'b1, 3'd2);
        step();
        hwdata = 32'hDEADBEEF;
        checks++;
        if (ro0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_rdy: got %0b want 1", ro0); end
        set_ap(12'h010, 1'b0, 3'd2);
        step();
        set_idle();
        checks += 3;
        if (ro0 !== 1'b1)         begin errors++; $display("FAIL b2b_rd_rdy: got %0b want 1", ro0); end
        if (rsp0 !== 1'b0)        begin errors++; $display("FAIL b2b_rd_resp: got %0b want 0", rsp0); end
        if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_raw: got %08h want deadbeef", rd0); end
        step();
        checks++;
        if (rd0 !== 32'h0) begin errors++; $display("FAIL b2b_idle_rdata: got %08h want 0", rd0); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        sel_dut = 1'b0;
        bus_write(12'h010, 3'd2, 32'h11223344);
        bus_write(12'h013, 3'd0, 32'h5A5A5A5A);
        bus_read(12'h010, d);
        checks++;
        if (d !== 32'h5A223344) begin errors++; $display("FAIL lane_byte: got %08h want 5a223344", d); end
        bus_write(12'h010, 3'd1, 32'hA5A5A5A5);
        bus_read(12'h010, d);
        checks++;
        if (d !== 32'h5A22A5A5) begin errors++; $display("FAIL lane_half: got %08h want 5a22a5a5", d); end
    endtask

    task automatic test_wait_states();
        sel_dut = 1'b1;
        bus_write(12'h020, 3'd2, 32'hCAFEF00D);
        set_ap(12'h020, 1'b0, 3'd2);
        step();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (ro3 !== 1'b0)  begin errors++; $display("FAIL wait_rdy_%0d: got %0b want 0", i, ro3); end
            if (rd3 !== 32'h0) begin errors++; $display("FAIL wait_rdata_%0d: got %08h want 0", i, rd3); end
            step();
        end
        checks += 2;
        if (ro3 !== 1'b1)         begin errors++; $display("FAIL wait_done_rdy: got %0b want 1", ro3); end
        if (rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_data: got %08h want cafef00d", rd3); end
        step();
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic [11:0] ea [2] = '{12'h012, 12'h000};
        logic [2:0]  es [2] = '{3'd2, 3'd3};
        sel_dut = 1'b0;
        bus_write(12'h000, 3'd2, 32'h01020304);
        for (int i = 0; i < 2; i++) begin
            set_ap(ea[i], 1'b1, es[i]);
            step();
            hwdata = 32'hFFFFFFFF;
            set_idle();
            checks += 2;
            if (ro0 !== 1'b0)  begin errors++; $display("FAIL err1_rdy_%0d: got %0b want 0", i, ro0); end
            if (rsp0 !== 1'b1) begin errors++; $display("FAIL err1_resp_%0d: got %0b want 1", i, rsp0); end
            step();
            checks += 2;
            if (ro0 !== 1'b1)  begin errors++; $display("FAIL err2_rdy_%0d: got %0b want 1", i, ro0); end
            if (rsp0 !== 1'b1) begin errors++; $display("FAIL err2_resp_%0d: got %0b want 1", i, rsp0); end
            step();
            checks += 2;
            if (ro0 !== 1'b1)  begin errors++; $display("FAIL err_idle_rdy_%0d: got %0b want 1", i, ro0); end
            if (rsp0 !== 1'b0) begin errors++; $display("FAIL err_idle_resp_%0d: got %0b want 0", i, rsp0); end
        end
        bus_read(12'h010, d);
        checks++;
        if (d !== 32'h5A22A5A5) begin errors++; $display("FAIL err_mem_010: got %08h want 5a22a5a5", d); end
        bus_read(12'h000, d);
        checks++;
        if (d !== 32'h01020304) begin errors++; $display("FAIL err_mem_000: got %08h want 01020304", d); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        sel_dut = 1'b1;
        bus_write(12'h030, 3'd2, 32'h12345678);
        set_ap(12'h030, 1'b1, 3'd2);
        step();
        hwdata = 32'h87654321;
        set_idle();
        step();
        checks++;
        if (ro3 !== 1'b0) begin errors++; $display("FAIL rst_pre_rdy: got %0b want 0", ro3); end
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        checks += 2;
        if (ro3 !== 1'b1)  begin errors++; $display("FAIL rst_mid_rdy: got %0b want 1", ro3); end
        if (rsp3 !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %0b want 0", rsp3); end
        step();
        step();
        bus_read(12'h030, d);
        checks++;
        if (d !== 32'h12345678) begin errors++; $display("FAIL rst_discard: got %08h want 12345678", d); end
    endtask

    initial begin
        hreset  = 1'b1;
        bus_sel = 1'b0;
        sel_dut = 1'b0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd2;
        hburst  = 3'd0;
        hprot   = 4'h3;
        hwdata  = '0;
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
